// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer handshake bundle: decoder-side inputs and PC/status outputs.
interface fetch_ctrl_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic [3:0]       opcode;
  logic [PC_W-1:0]  jmp_loc;
  logic             eq;
  logic             lt_u;
  logic             lt_s;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid;
  logic             halted;
  logic             done;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, stall, opcode, jmp_loc, eq, lt_u, lt_s,
    input  pc, fetch_valid, halted, done, retired
  );

  modport slave (
    input  start, stall, opcode, jmp_loc, eq, lt_u, lt_s,
    output pc, fetch_valid, halted, done, retired
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Program counter / fetch sequencer: picks next PC from the decoded opcode and
// branch flags, stalls on request, stops on HALT and counts retirements.
module fetch_ctrl #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  fetch_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_BLS  = 4'b1111;
  localparam logic [3:0] OP_HALT = 4'b1110;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    done_d    = 1'b0;
    pc_inc    = pc_q + PC_W'(1);

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          pc_d      = RESET_PC;
          retired_d = '0;
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          retired_d = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
          // Unlisted or unknown opcodes fall to the sequential default.
          case (bus.opcode)
            OP_JMP:  pc_d = bus.jmp_loc;
            OP_BNE:  pc_d = !bus.eq  ? bus.jmp_loc : pc_inc;
            OP_BEQ:  pc_d = bus.eq   ? bus.jmp_loc : pc_inc;
            OP_BLT:  pc_d = bus.lt_u ? bus.jmp_loc : pc_inc;
            OP_BLS:  pc_d = bus.lt_s ? bus.jmp_loc : pc_inc;
            OP_HALT: begin
              state_d = ST_HALT;
              done_d  = 1'b1;
            end
            default: pc_d = pc_inc;
          endcase
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pc_d      = RESET_PC;
        retired_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      done_q    <= done_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = (state_q == ST_RUN);
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.done        = done_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each step queues its expected PC/status and
// compares it against the DUT one edge later.
module tb_fetch_ctrl;

  logic clk;
  logic rst_n;
  int unsigned tests;
  int unsigned fails;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ret;
    logic        fv;
    logic        hlt;
    logic        dn;
  } exp_t;

  exp_t sb[$];

  fetch_ctrl_if #(.PC_W(16), .CNT_W(16)) bus ();

  fetch_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".pc"},      32'(bus.pc),          32'(e.pc));
    check({tag, ".retired"}, 32'(bus.retired),     32'(e.ret));
    check({tag, ".fv"},      32'(bus.fetch_valid), 32'(e.fv));
    check({tag, ".halted"},  32'(bus.halted),      32'(e.hlt));
    check({tag, ".done"},    32'(bus.done),        32'(e.dn));
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [15:0] loc,
                      input logic e, input logic lu, input logic ls,
                      input logic st, input logic sr,
                      input logic [15:0] epc, input logic [15:0] eret,
                      input logic efv, input logic eh, input logic ed);
    exp_t x;
    bus.opcode  = op;
    bus.jmp_loc = loc;
    bus.eq      = e;
    bus.lt_u    = lu;
    bus.lt_s    = ls;
    bus.stall   = st;
    bus.start   = sr;
    sb.push_back('{pc: epc, ret: eret, fv: efv, hlt: eh, dn: ed});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_all(tag, x);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stall = 1'b0; bus.opcode = 4'b0111;
    bus.jmp_loc = '0; bus.eq = 1'b0; bus.lt_u = 1'b0; bus.lt_s = 1'b0;

    @(posedge clk);
    #1;
    check_all("reset", '{pc: 16'h0, ret: 16'h0, fv: 1'b0, hlt: 1'b0, dn: 1'b0});
    rst_n = 1'b1;

    step("idle_ign",  4'b1110, 16'h0, 0,0,0, 1, 0, 16'd0, 16'd0, 0, 0, 0);
    step("start",     4'b0111, 16'h0, 0,0,0, 0, 1, 16'd0, 16'd0, 1, 0, 0);
    for (int i = 1; i <= 5; i++)
      step("seq", 4'b0111, 16'h0, 0,0,0, 0, 0, 16'(i), 16'(i), 1, 0, 0);
    step("halt",      4'b1110, 16'h0, 0,0,0, 0, 0, 16'd5, 16'd6, 0, 1, 1);
    step("halt_hold", 4'b0010, 16'h9, 0,0,0, 1, 0, 16'd5, 16'd6, 0, 1, 0);

    step("restart",   4'b0111, 16'h0, 0,0,0, 0, 1, 16'd0, 16'd0, 1, 0, 0);
    for (int i = 1; i <= 3; i++)
      step("seq2", 4'b0111, 16'h0, 0,0,0, 0, 0, 16'(i), 16'(i), 1, 0, 0);
    step("jmp",       4'b0010, 16'd10, 0,0,0, 0, 0, 16'd10, 16'd4, 1, 0, 0);
    step("beq_nt",    4'b1011, 16'd50, 0,0,0, 0, 0, 16'd11, 16'd5, 1, 0, 0);
    step("beq_t",     4'b1011, 16'd20, 1,0,0, 0, 0, 16'd20, 16'd6, 1, 0, 0);
    step("bls_t",     4'b1111, 16'd30, 0,0,1, 0, 0, 16'd30, 16'd7, 1, 0, 0);
    step("blt_nt",    4'b1100, 16'd40, 0,0,1, 0, 0, 16'd31, 16'd8, 1, 0, 0);
    step("bne_t",     4'b1010, 16'd7,  0,0,0, 0, 0, 16'd7,  16'd9, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("halt_stall", 4'b1110, 16'h0, 0,0,0, 1, 0, 16'd7, 16'd9, 1, 0, 0);
    step("halt2",     4'b1110, 16'h0, 0,0,0, 0, 0, 16'd7, 16'd10, 0, 1, 1);
    step("halt2_hold",4'b1110, 16'h0, 0,0,0, 0, 0, 16'd7, 16'd10, 0, 1, 0);

    step("restart_st",4'b0111, 16'h0, 0,0,0, 1, 1, 16'd0, 16'd0, 1, 0, 0);
    step("xop",       4'bxxxx, 16'h0, 0,0,0, 0, 0, 16'd1, 16'd1, 1, 0, 0);
    step("jmp_stall", 4'b0010, 16'hFFFF, 0,0,0, 1, 0, 16'd1, 16'd1, 1, 0, 0);
    step("jmp_max",   4'b0010, 16'hFFFF, 0,0,0, 0, 0, 16'hFFFF, 16'd2, 1, 0, 0);
    step("pc_wrap",   4'b0000, 16'h0, 0,0,0, 0, 0, 16'h0000, 16'd3, 1, 0, 0);
    step("jmp12",     4'b0010, 16'd12, 0,0,0, 0, 0, 16'd12, 16'd4, 1, 0, 0);

    // Asynchronous reset between edges must clear outputs before the next edge.
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", '{pc: 16'h0, ret: 16'h0, fv: 1'b0, hlt: 1'b0, dn: 1'b0});
    #1 rst_n = 1'b1;

    step("start3",    4'b0111, 16'h0, 0,0,0, 0, 1, 16'd0, 16'd0, 1, 0, 0);
    step("halt3",     4'b1110, 16'h0, 0,0,0, 0, 0, 16'd0, 16'd1, 0, 1, 1);
    step("restart3",  4'b0111, 16'h0, 0,0,0, 0, 1, 16'd0, 16'd0, 1, 0, 0);
    step("start_run", 4'b0111, 16'h0, 0,0,0, 0, 1, 16'd1, 16'd1, 1, 0, 0);

    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.opcode = 4'b0111;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_retired", 32'(bus.retired), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    check("sat_hold", 32'(bus.retired), 32'h0000_FFFF);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
